traffic_light_monitor: RTL and testbench

Passive checker on the lamp outputs of the traffic-light controller, clocked by the same i_clk.
- Follows the phase sequence RED -> YELLOW_2 -> GREEN -> YELLOW_1 -> RED and measures each phase's dwell in clock cycles.
- Flags illegal lamp combinations, out-of-order transitions and dwell violations, and counts completed light cycles.
- Used in the system testbench and as an optional on-chip safety monitor.

---
 rtl/traffic_light_monitor.sv | 227 ++++++++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - passive phase/dwell checker for traffic-light lamp outputs
// Optional feature macro: TLM_DWELL_CHECK_EN (early/late dwell checks)
module traffic_light_monitor #(
  parameter int COUNT_WIDTH   = 32,
  parameter int GLOW_RED      = 48,
  parameter int GLOW_YELLOW_1 = 12,
  parameter int GLOW_GREEN    = 48,
  parameter int GLOW_YELLOW_2 = 12,
  parameter int CYC_WIDTH     = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_red,
  input  logic                 i_yellow,
  input  logic                 i_green,
  input  logic                 i_clr,
  output logic                 o_locked,
  output logic [1:0]           o_phase,
  output logic                 o_err,
  output logic [2:0]           o_err_code,
  output logic                 o_err_sticky,
  output logic [CYC_WIDTH-1:0] o_cycles
);

  // Low two bits equal the reported phase number; bit 2 marks the unlocked state,
  // so o_locked and o_phase come straight off the state flops.
  typedef enum logic [2:0] {
    ST_RED      = 3'b000,
    ST_YELLOW_2 = 3'b001,
    ST_GREEN    = 3'b010,
    ST_YELLOW_1 = 3'b011,
    ST_SYNC     = 3'b100
  } state_t;

  typedef enum logic [1:0] {
    LAMP_NONE = 2'd0,
    LAMP_R    = 2'd1,
    LAMP_Y    = 2'd2,
    LAMP_G    = 2'd3
  } lamp_t;

  localparam logic [2:0] ERR_ILLEGAL = 3'd1;
  localparam logic [2:0] ERR_ORDER   = 3'd2;
`ifdef TLM_DWELL_CHECK_EN
  localparam logic [2:0] ERR_EARLY   = 3'd3;
  localparam logic [2:0] ERR_LATE    = 3'd4;
`endif

  state_t                 state, state_nx;
  lamp_t                  prev_lamp, prev_lamp_nx;
  lamp_t                  last_non_y, last_non_y_nx;
  logic                   err_q, err_nx;
  logic [2:0]             code_q, code_nx;
  logic                   sticky_q, sticky_nx;
  logic [CYC_WIDTH-1:0]   cycles_q, cycles_nx;
`ifdef TLM_DWELL_CHECK_EN
  logic [COUNT_WIDTH-1:0] dwell, dwell_nx;
  logic [COUNT_WIDTH-1:0] glow;
`endif

  logic       sample_valid;
  lamp_t      sample_lamp;
  lamp_t      own_lamp;
  lamp_t      succ_lamp;
  logic       err_hit;
  logic [2:0] err_kind;
  logic       advance;
  logic       cyc_inc;

  // Decode the lamp sample and the lamps expected for the current phase.
  always_comb begin
    sample_valid = 1'b0;
    sample_lamp  = LAMP_NONE;
    case ({i_red, i_yellow, i_green})
      3'b100:  begin sample_valid = 1'b1; sample_lamp = LAMP_R; end
      3'b010:  begin sample_valid = 1'b1; sample_lamp = LAMP_Y; end
      3'b001:  begin sample_valid = 1'b1; sample_lamp = LAMP_G; end
      default: begin sample_valid = 1'b0; sample_lamp = LAMP_NONE; end
    endcase
    own_lamp  = LAMP_NONE;
    succ_lamp = LAMP_NONE;
    case (state)
      ST_RED:      begin own_lamp = LAMP_R; succ_lamp = LAMP_Y; end
      ST_YELLOW_2: begin own_lamp = LAMP_Y; succ_lamp = LAMP_G; end
      ST_GREEN:    begin own_lamp = LAMP_G; succ_lamp = LAMP_Y; end
      ST_YELLOW_1: begin own_lamp = LAMP_Y; succ_lamp = LAMP_R; end
      default:     begin own_lamp = LAMP_NONE; succ_lamp = LAMP_NONE; end
    endcase
`ifdef TLM_DWELL_CHECK_EN
    case (state)
      ST_RED:      glow = COUNT_WIDTH'(GLOW_RED);
      ST_YELLOW_2: glow = COUNT_WIDTH'(GLOW_YELLOW_2);
      ST_GREEN:    glow = COUNT_WIDTH'(GLOW_GREEN);
      default:     glow = COUNT_WIDTH'(GLOW_YELLOW_1);
    endcase
`endif
  end

  // Next-state, lamp history, error classification and output register inputs.
  always_comb begin
    state_nx      = state;
    prev_lamp_nx  = sample_valid ? sample_lamp : LAMP_NONE;
    last_non_y_nx = last_non_y;
    err_hit       = 1'b0;
    err_kind      = 3'd0;
    advance       = 1'b0;
    cyc_inc       = 1'b0;
`ifdef TLM_DWELL_CHECK_EN
    dwell_nx      = dwell;
`endif
    if (!sample_valid) begin
      last_non_y_nx = LAMP_NONE;
    end else if (sample_lamp != LAMP_Y) begin
      last_non_y_nx = sample_lamp;
    end

    if (state == ST_SYNC) begin
      if (sample_valid) begin
        if (prev_lamp == LAMP_R && sample_lamp == LAMP_Y) begin
          state_nx = ST_YELLOW_2;
        end else if (prev_lamp == LAMP_G && sample_lamp == LAMP_Y) begin
          state_nx = ST_YELLOW_1;
        end else if (prev_lamp == LAMP_Y && sample_lamp == LAMP_G && last_non_y == LAMP_R) begin
          state_nx = ST_GREEN;
        end else if (prev_lamp == LAMP_Y && sample_lamp == LAMP_R && last_non_y == LAMP_G) begin
          state_nx = ST_RED;
        end
`ifdef TLM_DWELL_CHECK_EN
        dwell_nx = COUNT_WIDTH'(1);
`endif
      end
    end else if (!sample_valid) begin
      err_hit  = 1'b1;
      err_kind = ERR_ILLEGAL;
    end else if (sample_lamp == own_lamp) begin
`ifdef TLM_DWELL_CHECK_EN
      if (dwell == glow) begin
        err_hit  = 1'b1;
        err_kind = ERR_LATE;
      end else begin
        dwell_nx = dwell + 1'b1;
      end
`endif
    end else if (sample_lamp == succ_lamp) begin
`ifdef TLM_DWELL_CHECK_EN
      if (dwell < glow) begin
        err_hit  = 1'b1;
        err_kind = ERR_EARLY;
      end else begin
        advance = 1'b1;
      end
`else
      advance = 1'b1;
`endif
    end else begin
      err_hit  = 1'b1;
      err_kind = ERR_ORDER;
    end

    if (advance) begin
      state_nx = state_t'({1'b0, state[1:0] + 2'd1});
      cyc_inc  = (state == ST_YELLOW_1);
`ifdef TLM_DWELL_CHECK_EN
      dwell_nx = COUNT_WIDTH'(1);
`endif
    end
    if (err_hit) begin
      state_nx = ST_SYNC;
`ifdef TLM_DWELL_CHECK_EN
      dwell_nx = '0;
`endif
    end

    // Clear first so that an error or cycle completion in the same cycle wins.
    err_nx    = err_hit;
    code_nx   = code_q;
    sticky_nx = sticky_q;
    cycles_nx = cycles_q;
    if (i_clr) begin
      code_nx   = 3'd0;
      sticky_nx = 1'b0;
      cycles_nx = '0;
    end
    if (err_hit) begin
      code_nx   = err_kind;
      sticky_nx = 1'b1;
    end
    if (cyc_inc) begin
      cycles_nx = cycles_nx + 1'b1;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_SYNC;
      prev_lamp  <= LAMP_NONE;
      last_non_y <= LAMP_NONE;
      err_q      <= 1'b0;
      code_q     <= 3'd0;
      sticky_q   <= 1'b0;
      cycles_q   <= '0;
`ifdef TLM_DWELL_CHECK_EN
      dwell      <= '0;
`endif
    end else begin
      state      <= state_nx;
      prev_lamp  <= prev_lamp_nx;
      last_non_y <= last_non_y_nx;
      err_q      <= err_nx;
      code_q     <= code_nx;
      sticky_q   <= sticky_nx;
      cycles_q   <= cycles_nx;
`ifdef TLM_DWELL_CHECK_EN
      dwell      <= dwell_nx;
`endif
    end
  end

  assign o_locked     = ~state[2];
  assign o_phase      = state[1:0];
  assign o_err        = err_q;
  assign o_err_code   = code_q;
  assign o_err_sticky = sticky_q;
  assign o_cycles     = cycles_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb/tb_traffic_light_monitor.sv - self-checking bench for traffic_light_monitor
module tb_traffic_light_monitor;

  localparam int R = 0, Y = 1, G = 2, NONE = -1;
`ifdef TLM_DWELL_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        red = 1'b0, yellow = 1'b0, green = 1'b0, clr = 1'b0;
  logic        locked, err, err_sticky;
  logic [1:0]  phase;
  logic [2:0]  err_code;
  logic [15:0] cycles;

  traffic_light_monitor dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_red(red), .i_yellow(yellow), .i_green(green),
    .i_clr(clr), .o_locked(locked), .o_phase(phase), .o_err(err), .o_err_code(err_code),
    .o_err_sticky(err_sticky), .o_cycles(cycles)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: phase index 0..3 walks RED, YELLOW_2, GREEN, YELLOW_1.
  int glow [4] = '{48, 12, 48, 12};
  int plamp[4] = '{R, Y, G, Y};
  bit m_locked, m_err, m_sticky;
  int m_phase, m_dwell, m_prev, m_lny, m_code, m_cycles;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_err = 0; m_sticky = 0; m_phase = 0; m_dwell = 0;
    m_prev = NONE; m_lny = NONE; m_code = 0; m_cycles = 0;
  endtask

  task automatic model_step(input bit r, input bit y, input bit g, input bit c);
    int  n;
    bit  valid;
    int  lamp;
    int  kind;
    bit  inc;
    int  target;
    n     = int'(r) + int'(y) + int'(g);
    valid = (n == 1);
    lamp  = r ? R : (y ? Y : G);
    kind  = 0;
    inc   = 0;
    if (!m_locked) begin
      if (valid) begin
        target = -1;
        if (m_prev == R && lamp == Y) target = 1;
        else if (m_prev == G && lamp == Y) target = 3;
        else if (m_prev == Y && lamp == G && m_lny == R) target = 2;
        else if (m_prev == Y && lamp == R && m_lny == G) target = 0;
        if (target >= 0) begin
          m_locked = 1; m_phase = target; m_dwell = 1;
        end
      end
    end else if (!valid) begin
      kind = 1;
    end else if (lamp == plamp[m_phase]) begin
      if (CHECK && m_dwell == glow[m_phase]) kind = 4;
      else m_dwell++;
    end else if (lamp == plamp[(m_phase + 1) % 4]) begin
      if (CHECK && m_dwell < glow[m_phase]) kind = 3;
      else begin
        inc = (m_phase == 3);
        m_phase = (m_phase + 1) % 4;
        m_dwell = 1;
      end
    end else begin
      kind = 2;
    end
    m_prev = valid ? lamp : NONE;
    if (!valid) m_lny = NONE;
    else if (lamp != Y) m_lny = lamp;
    m_err = (kind != 0);
    if (c) begin m_sticky = 0; m_code = 0; m_cycles = 0; end
    if (kind != 0) begin m_code = kind; m_sticky = 1; m_locked = 0; end
    if (inc) m_cycles = (m_cycles + 1) % 65536;
  endtask

  task automatic step(input bit r, input bit y, input bit g, input bit c);
    red = r; yellow = y; green = g; clr = c;
    @(posedge clk);
    #2;
    model_step(r, y, g, c);
    chk("m_locked", int'(locked), int'(m_locked));
    chk("m_err", int'(err), int'(m_err));
    chk("m_code", int'(err_code), m_code);
    chk("m_sticky", int'(err_sticky), int'(m_sticky));
    chk("m_cycles", int'(cycles), m_cycles);
    if (m_locked) chk("m_phase", int'(phase), m_phase);
  endtask

  task automatic gen(input int lamp, input int n);
    for (int i = 0; i < n; i++) step(lamp == R, lamp == Y, lamp == G, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 0; red = 0; yellow = 0; green = 0; clr = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_locked", int'(locked), 0);
    chk("rst_phase", int'(phase), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_code", int'(err_code), 0);
    chk("rst_sticky", int'(err_sticky), 0);
    chk("rst_cycles", int'(cycles), 0);
    rst_n = 1;
    model_reset();
  endtask

  typedef struct {
    bit r, y, g, c;
    bit e_locked;
    int e_phase;
    bit e_err;
    int e_code;
    bit e_sticky;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int len, lamp, sel;
    bit inj_clr;
    logic [2:0] bad_combo;

    //            r y g c  lk ph er code st
    tbl[0]  = '{1,0,0,0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0,1,0,0, 1, 1, 0, 0, 0};
    tbl[2]  = '{1,0,0,0, 0, 0, 1, 2, 1};
    tbl[3]  = '{1,0,1,0, 0, 0, 0, 2, 1};
    tbl[4]  = '{0,1,0,0, 0, 0, 0, 2, 1};
    tbl[5]  = '{0,0,1,0, 0, 0, 0, 2, 1};
    tbl[6]  = '{0,1,0,0, 1, 3, 0, 2, 1};
    tbl[7]  = '{0,1,0,1, 1, 3, 0, 0, 0};
    tbl[8]  = '{0,0,1,0, 0, 0, 1, 2, 1};
    tbl[9]  = '{0,0,0,0, 0, 0, 0, 2, 1};
    tbl[10] = '{1,0,0,1, 0, 0, 0, 0, 0};
    tbl[11] = '{0,1,0,0, 1, 1, 0, 0, 0};
    tbl[12] = '{0,1,1,0, 0, 0, 1, 1, 1};

    do_reset();
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].r, tbl[i].y, tbl[i].g, tbl[i].c);
      chk($sformatf("tbl%0d_locked", i), int'(locked), int'(tbl[i].e_locked));
      chk($sformatf("tbl%0d_err", i), int'(err), int'(tbl[i].e_err));
      chk($sformatf("tbl%0d_code", i), int'(err_code), tbl[i].e_code);
      chk($sformatf("tbl%0d_sticky", i), int'(err_sticky), int'(tbl[i].e_sticky));
      if (tbl[i].e_locked) chk($sformatf("tbl%0d_phase", i), int'(phase), tbl[i].e_phase);
    end

    // Generator with default timing from a shared reset.
    do_reset();
    gen(R, 48);
    step(0, 1, 0, 0);
    chk("gen_lock", int'(locked), 1);
    chk("gen_lock_phase", int'(phase), 1);
    gen(Y, 11); gen(G, 48); gen(Y, 12);
    chk("gen_cyc0", int'(cycles), 0);
    step(1, 0, 0, 0);
    chk("gen_cyc1", int'(cycles), 1);
    gen(R, 47); gen(Y, 12); gen(G, 48); gen(Y, 12);
    chk("gen_cyc1_hold", int'(cycles), 1);
    step(1, 0, 0, 0);
    chk("gen_cyc2", int'(cycles), 2);
    chk("gen_sticky", int'(err_sticky), 0);

    // GREEN held 40 then yellow.
    gen(R, 47); gen(Y, 12); gen(G, 40);
    step(0, 1, 0, 0);
    if (CHECK) begin
      chk("early_err", int'(err), 1);
      chk("early_code", int'(err_code), 3);
      chk("early_locked", int'(locked), 0);
    end else begin
      chk("early_noerr", int'(err), 0);
      chk("early_phase", int'(phase), 3);
    end

    // GREEN held 49 samples.
    gen(Y, 11); gen(R, 48); gen(Y, 12); gen(G, 48);
    step(0, 0, 1, 0);
    if (CHECK) begin
      chk("late_code", int'(err_code), 4);
      chk("late_locked", int'(locked), 0);
    end else begin
      chk("late_noerr", int'(err), 0);
      chk("late_locked", int'(locked), 1);
    end

    // Illegal combination while locked in RED, then re-lock.
    gen(Y, 12);
    step(1, 0, 0, 0);
    chk("red_locked", int'(locked), 1);
    chk("red_phase", int'(phase), 0);
    gen(R, 9);
    step(1, 0, 1, 0);
    chk("ill_code", int'(err_code), 1);
    chk("ill_sticky", int'(err_sticky), 1);
    chk("ill_locked", int'(locked), 0);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    chk("relock", int'(locked), 1);

    // Full RED dwell then green: order error.
    gen(Y, 11); gen(G, 48); gen(Y, 12); gen(R, 48);
    step(0, 0, 1, 0);
    chk("order_code", int'(err_code), 2);
    chk("order_locked", int'(locked), 0);

    // Clear while locked, then clear colliding with an error.
    step(0, 1, 0, 0);
    chk("clr_pre_locked", int'(locked), 1);
    step(0, 1, 0, 1);
    chk("clr_sticky", int'(err_sticky), 0);
    chk("clr_code", int'(err_code), 0);
    chk("clr_cycles", int'(cycles), 0);
    chk("clr_locked", int'(locked), 1);
    step(1, 1, 1, 1);
    chk("clr_vs_err_code", int'(err_code), 1);
    chk("clr_vs_err_sticky", int'(err_sticky), 1);

    // Asynchronous reset mid-phase.
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    gen(Y, 3);
    chk("pre_arst_locked", int'(locked), 1);
    #3;
    rst_n = 0;
    #1;
    chk("arst_locked", int'(locked), 0);
    chk("arst_sticky", int'(err_sticky), 0);
    @(posedge clk);
    #2;
    rst_n = 1;
    model_reset();

    // Randomized near-legal traffic against the model.
    for (int k = 0; k < 22; k++) begin
      for (int ph = 0; ph < 4; ph++) begin
        sel = $urandom_range(0, 9);
        len = glow[ph] + ((sel == 0) ? -1 : (sel == 1) ? 1 : 0);
        lamp = plamp[ph];
        if ($urandom_range(0, 29) == 0) lamp = (lamp + 1 + $urandom_range(0, 1)) % 3;
        for (int i = 0; i < len; i++) begin
          inj_clr = ($urandom_range(0, 39) == 0);
          if ($urandom_range(0, 149) == 0) begin
            bad_combo = 3'($urandom_range(0, 7));
            if (bad_combo == 3'b100 || bad_combo == 3'b010 || bad_combo == 3'b001) bad_combo = 3'b111;
            step(bad_combo[2], bad_combo[1], bad_combo[0], inj_clr);
          end else begin
            step(lamp == R, lamp == Y, lamp == G, inj_clr);
          end
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
